vga_capture: RTL

- Receiver end of the VGA text-display output: consumes hsync, vsync and 3-bit rgb exactly as the display block drives its pins.
- Recovers the pixel grid, pixel coordinates and frame boundaries, and emits a per-pixel valid stream.
- Provides on-chip screen capture (loopback self-check, pixel dump) and timing-violation monitoring of the 640x480@60 generator.

---
 rtl/vga_capture.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// VGA receiver: recovers the pixel grid from hsync/vsync/rgb pins, emits a
// per-pixel capture stream and monitors line/sync/frame timing for lock.
module vga_capture #(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_PHASE = 2,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_OFFSET     = 144,
  parameter int H_ACTIVE     = 640,
  parameter int V_TOTAL      = 525,
  parameter int V_OFFSET     = 35,
  parameter int V_ACTIVE     = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       line_end,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SAMPLE_AT = DW'(SAMPLE_PHASE);
  localparam logic [9:0]    HC_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    HS_WIDTH  = 10'(H_SYNC);
  localparam logic [9:0]    HA_FIRST  = 10'(H_OFFSET);
  localparam logic [9:0]    HA_LAST   = 10'(H_OFFSET + H_ACTIVE - 1);
  localparam logic [9:0]    VC_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    VA_FIRST  = 10'(V_OFFSET);
  localparam logic [9:0]    VA_LAST   = 10'(V_OFFSET + V_ACTIVE - 1);
  localparam logic [9:0]    CNT_MAX   = 10'h3FF;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic          hsync_r, vsync_r, hsync_d_r, vsync_d_r;
  logic [2:0]    rgb_r;
  logic [DW-1:0] div_r;
  logic [9:0]    hc_r, vc_r, hlow_r;
  logic          vs_pend_r;
  state_t        state_r, state_next_s;
  logic [GW-1:0] good_r, good_next_s;

  logic          hf_s, hr_s, vf_s, wrap_s, fs_s, checking_s;
  logic          line_bad_s, sync_bad_s, frame_bad_s;
  logic          h_fault_s, v_fault_s, sample_s;
  logic [9:0]    hlow_total_s;

  // Pin capture stage and delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      hsync_d_r <= 1'b0;
      vsync_d_r <= 1'b0;
      rgb_r     <= 3'b000;
    end else begin
      hsync_r   <= hsync;
      vsync_r   <= vsync;
      hsync_d_r <= hsync_r;
      vsync_d_r <= vsync_r;
      rgb_r     <= rgb;
    end
  end

  // Edge events, timing checks and the capture decision
  always_comb begin
    hf_s       = hsync_d_r & ~hsync_r;
    hr_s       = ~hsync_d_r & hsync_r;
    vf_s       = vsync_d_r & ~vsync_r;
    wrap_s     = (div_r == DIV_LAST);
    fs_s       = hf_s & vs_pend_r;
    checking_s = (state_r != ST_SEARCH);
    // the pixel closing on this edge still counts toward the low width
    if (wrap_s && !hsync_d_r && (hlow_r != CNT_MAX)) begin
      hlow_total_s = hlow_r + 10'd1;
    end else begin
      hlow_total_s = hlow_r;
    end
    line_bad_s  = hf_s & ~((hc_r == HC_LAST) & (div_r == DIV_LAST));
    sync_bad_s  = hr_s & (hlow_total_s != HS_WIDTH);
    frame_bad_s = fs_s & (vc_r != VC_LAST);
    h_fault_s   = checking_s & (line_bad_s | sync_bad_s);
    v_fault_s   = checking_s & frame_bad_s;
    sample_s    = checking_s & (div_r == SAMPLE_AT)
                & (hc_r >= HA_FIRST) & (hc_r <= HA_LAST)
                & (vc_r >= VA_FIRST) & (vc_r <= VA_LAST);
  end

  // Pixel divider, horizontal/vertical counters and sync-low width
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_r     <= '0;
      hc_r      <= 10'd0;
      vc_r      <= 10'd0;
      hlow_r    <= 10'd0;
      vs_pend_r <= 1'b0;
    end else begin
      if (hf_s) begin
        div_r  <= '0;
        hc_r   <= 10'd0;
        hlow_r <= 10'd0;
      end else begin
        hlow_r <= hlow_total_s;
        if (wrap_s) begin
          div_r <= '0;
          if (hc_r != CNT_MAX) begin
            hc_r <= hc_r + 10'd1;
          end
        end else begin
          div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      if (fs_s) begin
        vc_r <= 10'd0;
      end else if (hf_s && (vc_r != CNT_MAX)) begin
        vc_r <= vc_r + 10'd1;
      end
      // a vsync fall coincident with the frame-starting hsync re-arms the pending flag
      if (vf_s) begin
        vs_pend_r <= 1'b1;
      end else if (fs_s) begin
        vs_pend_r <= 1'b0;
      end
    end
  end

  // Lock state machine: next state and good-frame count
  always_comb begin
    state_next_s = state_r;
    good_next_s  = good_r;
    case (state_r)
      ST_SEARCH: begin
        good_next_s = '0;
        if (fs_s) begin
          state_next_s = ST_TRACK;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_TRACK: begin
        if (h_fault_s || v_fault_s) begin
          state_next_s = ST_SEARCH;
          good_next_s  = '0;
        end else if (fs_s) begin
          if (good_r == GOOD_LAST) begin
            state_next_s = ST_LOCKED;
            good_next_s  = '0;
          end else begin
            state_next_s = ST_TRACK;
            good_next_s  = good_r + {{(GW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_next_s = ST_TRACK;
          good_next_s  = good_r;
        end
      end
      ST_LOCKED: begin
        good_next_s = '0;
        if (h_fault_s || v_fault_s) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_LOCKED;
        end
      end
      default: begin
        state_next_s = ST_SEARCH;
        good_next_s  = '0;
      end
    endcase
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_SEARCH;
      good_r  <= '0;
    end else begin
      state_r <= state_next_s;
      good_r  <= good_next_s;
    end
  end

  // Registered outputs; pixel data holds between strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 3'b000;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      pix_valid   <= sample_s;
      line_end    <= sample_s & (hc_r == HA_LAST);
      frame_start <= fs_s;
      locked      <= (state_next_s == ST_LOCKED);
      h_err       <= h_err | h_fault_s;
      v_err       <= v_err | v_fault_s;
      if (sample_s) begin
        pix_x   <= hc_r - HA_FIRST;
        pix_y   <= vc_r - VA_FIRST;
        pix_rgb <= rgb_r;
      end
    end
  end

endmodule
